// File: rtl/l1_mem_arbiter.sv
// Arbiter for the single cache-line memory port shared by the L1 I-cache miss
// path (read-only) and the L1 D-cache miss/flush path, with a hang watchdog.
module l1_mem_arbiter #(
  parameter bit          D_PRIORITY     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         i_req_read,
  input  logic [31:0]  i_req_addr,
  output logic         i_done,
  output logic [255:0] i_read_data,
  input  logic         d_req_read,
  input  logic         d_req_write,
  input  logic [31:0]  d_req_addr,
  input  logic [255:0] d_write_data,
  output logic         d_done,
  output logic [255:0] d_read_data,
  output logic         mem_req_read,
  output logic         mem_req_write,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_write_data,
  input  logic         mem_done,
  input  logic [255:0] mem_read_data,
  output logic         err_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_e         state_q, state_d;
  logic           last_d_q, last_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           i_done_q, i_done_d;
  logic [255:0]   i_read_data_q, i_read_data_d;
  logic           d_done_q, d_done_d;
  logic [255:0]   d_read_data_q, d_read_data_d;
  logic           mem_req_read_q, mem_req_read_d;
  logic           mem_req_write_q, mem_req_write_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [255:0]   mem_write_data_q, mem_write_data_d;
  logic           err_timeout_q, err_timeout_d;

  logic d_req, grant_d, grant_i, timed_out;

  always_comb begin
    state_d          = state_q;
    last_d_d         = last_d_q;
    cnt_d            = cnt_q;
    i_done_d         = 1'b0;
    d_done_d         = 1'b0;
    i_read_data_d    = i_read_data_q;
    d_read_data_d    = d_read_data_q;
    mem_req_read_d   = mem_req_read_q;
    mem_req_write_d  = mem_req_write_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    err_timeout_d    = err_timeout_q;
    d_req            = d_req_read | d_req_write;
    grant_d          = 1'b0;
    grant_i          = 1'b0;
    timed_out        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie in round-robin mode the side that did not win last time goes.
        if (d_req && i_req_read) grant_d = D_PRIORITY ? 1'b1 : !last_d_q;
        else                     grant_d = d_req;
        grant_i = i_req_read && !grant_d;

        if (grant_d) begin
          state_d         = BUSY_D;
          last_d_d        = 1'b1;
          cnt_d           = '0;
          mem_addr_d      = {d_req_addr[31:5], 5'b0};
          mem_req_write_d = d_req_write;
          mem_req_read_d  = !d_req_write;
          if (d_req_write) mem_write_data_d = d_write_data;
        end else if (grant_i) begin
          state_d         = BUSY_I;
          last_d_d        = 1'b0;
          cnt_d           = '0;
          mem_addr_d      = {i_req_addr[31:5], 5'b0};
          mem_req_write_d = 1'b0;
          mem_req_read_d  = 1'b1;
        end
      end

      BUSY_I, BUSY_D: begin
        if (!mem_done && (TIMEOUT_CYCLES != 0)) begin
          cnt_d     = cnt_q + 1'b1;
          timed_out = (cnt_d == TMO);
        end
        // A completion on the same edge as the timeout wins over the abort.
        if (mem_done || timed_out) begin
          state_d         = RESP;
          mem_req_read_d  = 1'b0;
          mem_req_write_d = 1'b0;
          err_timeout_d   = err_timeout_q | timed_out;
          if (state_q == BUSY_I) begin
            i_done_d      = 1'b1;
            i_read_data_d = mem_done ? mem_read_data : '0;
          end else begin
            d_done_d = 1'b1;
            if (!mem_done)          d_read_data_d = '0;
            else if (mem_req_read_q) d_read_data_d = mem_read_data;
          end
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_d_q         <= 1'b1;
      cnt_q            <= '0;
      i_done_q         <= 1'b0;
      i_read_data_q    <= '0;
      d_done_q         <= 1'b0;
      d_read_data_q    <= '0;
      mem_req_read_q   <= 1'b0;
      mem_req_write_q  <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      err_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_d_q         <= last_d_d;
      cnt_q            <= cnt_d;
      i_done_q         <= i_done_d;
      i_read_data_q    <= i_read_data_d;
      d_done_q         <= d_done_d;
      d_read_data_q    <= d_read_data_d;
      mem_req_read_q   <= mem_req_read_d;
      mem_req_write_q  <= mem_req_write_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      err_timeout_q    <= err_timeout_d;
    end
  end

  assign i_done         = i_done_q;
  assign i_read_data    = i_read_data_q;
  assign d_done         = d_done_q;
  assign d_read_data    = d_read_data_q;
  assign mem_req_read   = mem_req_read_q;
  assign mem_req_write  = mem_req_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: a D-priority and a round-robin instance share the
// stimulus; sel picks which one's outputs are observed.
module tb_l1_mem_arbiter;

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_req_read = 1'b0;
  logic [31:0]  i_req_addr = '0;
  logic         d_req_read = 1'b0;
  logic         d_req_write = 1'b0;
  logic [31:0]  d_req_addr = '0;
  logic [255:0] d_write_data = '0;
  logic         mem_done = 1'b0;
  logic [255:0] mem_read_data = '0;
  logic         sel = 1'b0;

  logic         p_i_done, p_d_done, p_rd, p_wr, p_err;
  logic [255:0] p_i_rdata, p_d_rdata, p_wdata;
  logic [31:0]  p_addr;
  logic         r_i_done, r_d_done, r_rd, r_wr, r_err;
  logic [255:0] r_i_rdata, r_d_rdata, r_wdata;
  logic [31:0]  r_addr;

  logic         o_i_done, o_d_done, o_rd, o_wr, o_err;
  logic [255:0] o_i_rdata, o_d_rdata, o_wdata;
  logic [31:0]  o_addr;
  logic [804:0] o_all;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 sys_clk = ~sys_clk;

  l1_mem_arbiter #(.D_PRIORITY(1'b1), .TIMEOUT_CYCLES(8), .CNT_W(16)) u_dut_p (
    .sys_clk(sys_clk), .rst(rst),
    .i_req_read(i_req_read), .i_req_addr(i_req_addr),
    .i_done(p_i_done), .i_read_data(p_i_rdata),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_write_data(d_write_data), .d_done(p_d_done), .d_read_data(p_d_rdata),
    .mem_req_read(p_rd), .mem_req_write(p_wr), .mem_addr(p_addr),
    .mem_write_data(p_wdata), .mem_done(mem_done), .mem_read_data(mem_read_data),
    .err_timeout(p_err)
  );

  l1_mem_arbiter #(.D_PRIORITY(1'b0), .TIMEOUT_CYCLES(8), .CNT_W(16)) u_dut_r (
    .sys_clk(sys_clk), .rst(rst),
    .i_req_read(i_req_read), .i_req_addr(i_req_addr),
    .i_done(r_i_done), .i_read_data(r_i_rdata),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_write_data(d_write_data), .d_done(r_d_done), .d_read_data(r_d_rdata),
    .mem_req_read(r_rd), .mem_req_write(r_wr), .mem_addr(r_addr),
    .mem_write_data(r_wdata), .mem_done(mem_done), .mem_read_data(mem_read_data),
    .err_timeout(r_err)
  );

  assign o_i_done  = sel ? r_i_done  : p_i_done;
  assign o_d_done  = sel ? r_d_done  : p_d_done;
  assign o_rd      = sel ? r_rd      : p_rd;
  assign o_wr      = sel ? r_wr      : p_wr;
  assign o_err     = sel ? r_err     : p_err;
  assign o_i_rdata = sel ? r_i_rdata : p_i_rdata;
  assign o_d_rdata = sel ? r_d_rdata : p_d_rdata;
  assign o_wdata   = sel ? r_wdata   : p_wdata;
  assign o_addr    = sel ? r_addr    : p_addr;
  assign o_all     = {o_i_done, o_i_rdata, o_d_done, o_d_rdata, o_rd, o_wr, o_addr, o_wdata, o_err};

  function automatic logic [255:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    i_req_read = 1'b0; i_req_addr = '0;
    d_req_read = 1'b0; d_req_write = 1'b0; d_req_addr = '0; d_write_data = '0;
    mem_done = 1'b0; mem_read_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    total++;
    if (o_all !== '0) begin bad++; $display("FAIL reset_p got=%h exp=0", o_all); end
    sel = 1'b1;
    total++;
    if (o_all !== '0) begin bad++; $display("FAIL reset_r got=%h exp=0", o_all); end
  endtask

  task automatic test_i_read();
    int unsigned hi;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    sel = 1'b0;
    do_reset();
    i_req_read = 1'b1; i_req_addr = 32'h0000_1234;
    hi = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_rd && !o_wr) hi++;
      if (c == 0) begin
        total++;
        if (o_addr !== 32'h0000_1220) begin bad++; $display("FAIL iread_addr got=%h exp=00001220", o_addr); end
      end
    end
    mem_done = 1'b1; mem_read_data = a5;
    tick();
    mem_done = 1'b0; mem_read_data = '0;
    if (o_rd) hi++;
    total++;
    if (hi !== 3) begin bad++; $display("FAIL iread_req_cycles got=%0d exp=3", hi); end
    total++;
    if ({o_i_done, o_d_done} !== 2'b10) begin bad++; $display("FAIL iread_done got=%b exp=10", {o_i_done, o_d_done}); end
    total++;
    if (o_i_rdata !== a5) begin bad++; $display("FAIL iread_data got=%h exp=%h", o_i_rdata, a5); end
    i_req_read = 1'b0;
    tick();
    total++;
    if ({o_i_done, o_d_done, o_rd, o_wr} !== 4'b0000 || o_i_rdata !== a5) begin
      bad++; $display("FAIL iread_after got=%b/%h exp=0000/%h", {o_i_done, o_d_done, o_rd, o_wr}, o_i_rdata, a5);
    end
  endtask

  task automatic test_priority();
    logic [255:0] w, rd;
    w = rnd_line(); rd = rnd_line();
    sel = 1'b0;
    do_reset();
    i_req_read = 1'b1; i_req_addr = 32'h0000_0100;
    d_req_write = 1'b1; d_req_addr = 32'h8000_0040; d_write_data = w;
    tick();
    total++;
    if ({o_rd, o_wr} !== 2'b01 || o_addr !== 32'h8000_0040 || o_wdata !== w) begin
      bad++; $display("FAIL prio_dgrant got=%b/%h exp=01/80000040", {o_rd, o_wr}, o_addr);
    end
    mem_done = 1'b1; mem_read_data = rd;
    tick();
    mem_done = 1'b0;
    total++;
    if ({o_i_done, o_d_done, o_rd, o_wr} !== 4'b0100) begin
      bad++; $display("FAIL prio_ddone got=%b exp=0100", {o_i_done, o_d_done, o_rd, o_wr});
    end
    total++;
    if (o_d_rdata !== '0) begin bad++; $display("FAIL prio_write_hold got=%h exp=0", o_d_rdata); end
    d_req_write = 1'b0;
    tick();
    total++;
    if ({o_i_done, o_d_done, o_rd, o_wr} !== 4'b0000) begin
      bad++; $display("FAIL prio_gap got=%b exp=0000", {o_i_done, o_d_done, o_rd, o_wr});
    end
    tick();
    total++;
    if ({o_rd, o_wr} !== 2'b10 || o_addr !== 32'h0000_0100) begin
      bad++; $display("FAIL prio_igrant got=%b/%h exp=10/00000100", {o_rd, o_wr}, o_addr);
    end
    mem_done = 1'b1; mem_read_data = rd;
    tick();
    mem_done = 1'b0;
    total++;
    if ({o_i_done, o_d_done} !== 2'b10 || o_i_rdata !== rd) begin
      bad++; $display("FAIL prio_idone got=%b/%h exp=10/%h", {o_i_done, o_d_done}, o_i_rdata, rd);
    end
    i_req_read = 1'b0;
  endtask

  task automatic test_round_robin();
    logic prev_req;
    int unsigned busy, k;
    logic got_d;
    sel = 1'b1;
    do_reset();
    i_req_read = 1'b1; i_req_addr = 32'h0000_1000;
    d_req_read = 1'b1; d_req_addr = 32'h0000_2000;
    prev_req = 1'b0; busy = 0; k = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      tick();
      mem_done = 1'b0;
      total++;
      if (o_rd && o_wr) begin bad++; $display("FAIL rr_both_req got=11 exp=not11"); end
      if (o_rd || o_wr) begin
        if (!prev_req) begin
          got_d = (o_addr == 32'h0000_2000);
          total++;
          if (got_d !== k[0]) begin bad++; $display("FAIL rr_order grant%0d got_d=%b exp_d=%b", k, got_d, k[0]); end
          k++;
          busy = 0;
        end
        busy++;
        if (busy == 2) begin mem_done = 1'b1; mem_read_data = rnd_line(); end
      end
      prev_req = o_rd | o_wr;
    end
    mem_done = 1'b0;
    total++;
    if (k !== 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", k); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [255:0] x;
    int unsigned hi;
    x = rnd_line() | 256'h1;
    sel = 1'b0;
    do_reset();
    i_req_read = 1'b1; i_req_addr = 32'h0000_3000;
    tick();
    mem_done = 1'b1; mem_read_data = x;
    tick();
    mem_done = 1'b0;
    i_req_read = 1'b0;
    total++;
    if (o_i_rdata !== x || o_err !== 1'b0) begin bad++; $display("FAIL to_preread got=%h/%b exp=%h/0", o_i_rdata, o_err, x); end
    tick();
    i_req_read = 1'b1; i_req_addr = 32'h0000_4000;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!o_rd) break;
      hi++;
    end
    i_req_read = 1'b0;
    total++;
    if (hi !== 8) begin bad++; $display("FAIL to_busy_cycles got=%0d exp=8", hi); end
    total++;
    if (o_i_done !== 1'b1 || o_i_rdata !== '0 || o_err !== 1'b1) begin
      bad++; $display("FAIL to_abort got=%b/%h/%b exp=1/0/1", o_i_done, o_i_rdata, o_err);
    end
    for (int c = 0; c < 5; c++) tick();
    total++;
    if (o_err !== 1'b1 || o_i_done !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b/%b exp=1/0", o_err, o_i_done); end
    do_reset();
    total++;
    if (o_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", o_err); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] x;
    x = rnd_line() | 256'h1;
    sel = 1'b0;
    do_reset();
    d_req_read = 1'b1; d_req_addr = 32'h0000_5000;
    tick();
    mem_done = 1'b1; mem_read_data = x;
    tick();
    mem_done = 1'b0; d_req_read = 1'b0;
    tick();
    d_req_read = 1'b1; d_req_addr = 32'h0000_6000;
    tick();
    total++;
    if ({o_rd, o_wr} !== 2'b10 || o_d_rdata !== x) begin bad++; $display("FAIL rmid_busy got=%b exp=10", {o_rd, o_wr}); end
    tick();
    rst = 1'b1; d_req_read = 1'b0;
    tick();
    total++;
    if (o_all !== '0) begin bad++; $display("FAIL rmid_clear got=%h exp=0", o_all); end
    rst = 1'b0;
    tick();
    mem_done = 1'b1; mem_read_data = rnd_line();
    tick();
    mem_done = 1'b0;
    total++;
    if (o_all !== '0) begin bad++; $display("FAIL rmid_stray got=%h exp=0", o_all); end
    tick();
    total++;
    if (o_all !== '0) begin bad++; $display("FAIL rmid_later got=%h exp=0", o_all); end
  endtask

  task automatic test_d_both();
    logic [255:0] w;
    logic [31:0] a;
    int unsigned pulses;
    w = rnd_line(); a = 32'h4567_89AB;
    sel = 1'b0;
    do_reset();
    d_req_read = 1'b1; d_req_write = 1'b1; d_req_addr = a; d_write_data = w;
    tick();
    total++;
    if ({o_rd, o_wr} !== 2'b01 || o_addr !== 32'h4567_89A0) begin
      bad++; $display("FAIL both_grant got=%b/%h exp=01/456789a0", {o_rd, o_wr}, o_addr);
    end
    d_req_read = 1'b0; d_req_addr = $urandom; d_write_data = ~w;
    tick();
    total++;
    if ({o_rd, o_wr} !== 2'b01 || o_addr !== 32'h4567_89A0 || o_wdata !== w) begin
      bad++; $display("FAIL both_stable got=%b/%h exp=01/456789a0", {o_rd, o_wr}, o_addr);
    end
    mem_done = 1'b1; mem_read_data = rnd_line();
    tick();
    mem_done = 1'b0;
    pulses = 0;
    if (o_d_done) pulses++;
    d_req_write = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_d_done) pulses++;
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL both_done_pulses got=%0d exp=1", pulses); end
  endtask

  // Random traffic against a transaction-level model: a free arbiter serves the
  // pending side chosen by the arbitration rule, memory answers after a random
  // number of busy cycles, and the arbiter is free again one cycle after done.
  task automatic test_random(input logic which, input int unsigned n_txn);
    logic e_rd, e_wr, e_idone, e_ddone, arb_free, in_txn, win_d, last_was_d;
    logic [255:0] e_iread, e_dread, t_wdata;
    logic [31:0] t_addr;
    int unsigned lat, busy_n, i_gap, d_gap, n_done, op;
    sel = which;
    do_reset();
    e_rd = 0; e_wr = 0; e_idone = 0; e_ddone = 0; e_iread = '0; e_dread = '0;
    arb_free = 1; in_txn = 0; win_d = 0; last_was_d = 1; t_addr = '0; t_wdata = '0;
    lat = 1; busy_n = 0; n_done = 0;
    i_gap = $urandom_range(3, 0); d_gap = $urandom_range(3, 0);
    for (int cyc = 0; cyc < 4000 && n_done < n_txn; cyc++) begin
      tick();
      total++;
      if ({o_rd, o_wr} !== {e_rd, e_wr}) begin bad++; $display("FAIL rnd_memreq cyc=%0d got=%b exp=%b", cyc, {o_rd, o_wr}, {e_rd, e_wr}); end
      if (e_rd || e_wr) begin
        total++;
        if (o_addr !== t_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, o_addr, t_addr); end
      end
      if (e_wr) begin
        total++;
        if (o_wdata !== t_wdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, o_wdata, t_wdata); end
      end
      total++;
      if ({o_i_done, o_d_done} !== {e_idone, e_ddone}) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, {o_i_done, o_d_done}, {e_idone, e_ddone}); end
      total++;
      if (o_i_rdata !== e_iread || o_d_rdata !== e_dread) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d got_i=%h exp_i=%h got_d=%h exp_d=%h", cyc, o_i_rdata, e_iread, o_d_rdata, e_dread);
      end
      total++;
      if (o_err !== 1'b0) begin bad++; $display("FAIL rnd_err cyc=%0d got=1 exp=0", cyc); end

      if (e_idone) begin n_done++; i_req_read = 1'b0; i_gap = $urandom_range(2, 0); end
      else if (!i_req_read) begin
        if (i_gap == 0) begin i_req_read = 1'b1; i_req_addr = $urandom; end
        else i_gap--;
      end
      if (e_ddone) begin n_done++; d_req_read = 1'b0; d_req_write = 1'b0; d_gap = $urandom_range(2, 0); end
      else if (!(d_req_read || d_req_write)) begin
        if (d_gap == 0) begin
          op = $urandom_range(2, 0);
          d_req_read = (op != 1); d_req_write = (op != 0);
          d_req_addr = $urandom; d_write_data = rnd_line();
        end else d_gap--;
      end
      if (in_txn && (e_rd || e_wr) && ($urandom_range(3, 0) == 0)) begin
        if (win_d) begin
          d_req_addr = $urandom; d_write_data = rnd_line();
          if (d_req_read && d_req_write) d_req_read = 1'b0;
        end else i_req_addr = $urandom;
      end

      mem_done = 1'b0; mem_read_data = rnd_line();
      e_idone = 0; e_ddone = 0;
      if (in_txn && (e_rd || e_wr)) begin
        busy_n++;
        if (busy_n == lat) begin
          mem_done = 1'b1;
          if (win_d) begin e_ddone = 1; if (!e_wr) e_dread = mem_read_data; end
          else begin e_idone = 1; e_iread = mem_read_data; end
          e_rd = 0; e_wr = 0; in_txn = 0; arb_free = 0;
        end
      end else if (arb_free) begin
        mem_done = ($urandom_range(3, 0) == 0);
        if (i_req_read || d_req_read || d_req_write) begin
          win_d = (d_req_read || d_req_write) && (!i_req_read || !which || !last_was_d);
          last_was_d = win_d;
          e_wr = win_d && d_req_write;
          e_rd = !e_wr;
          t_addr = (win_d ? d_req_addr : i_req_addr) & 32'hFFFF_FFE0;
          t_wdata = d_write_data;
          in_txn = 1; arb_free = 0; busy_n = 0;
          lat = $urandom_range(5, 1);
        end
      end else begin
        mem_done = ($urandom_range(3, 0) == 0);
        arb_free = 1;
      end
    end
    total++;
    if (n_done < n_txn) begin bad++; $display("FAIL rnd_progress got=%0d exp=%0d", n_done, n_txn); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_priority();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_d_both();
    test_random(1'b0, 150);
    test_random(1'b1, 150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single cache-line memory port between the L1 I-cache miss path (read-only) and the L1 D-cache miss/flush path (read and write).
- Sits between both L1 caches and the memory controller.
- Latches one request at a time, drives the memory port until it signals done, then returns the line to the winning requester with a one-cycle done pulse.
- A watchdog aborts hung transactions.

Parameters:
- D_PRIORITY, 1, 1 = D-cache always wins simultaneous requests; 0 = round-robin.
- TIMEOUT_CYCLES, 1024, busy cycles before abort; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter; TIMEOUT_CYCLES must be < 2^CNT_W.

Ports:
- sys_clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req_read  in  1  I-cache line read request; level, held until i_done.
- i_req_addr  in  32  I-cache request address; bits [4:0] ignored.
- i_done  out  1  one-cycle pulse: i_read_data is valid.
- i_read_data  out  256  line returned to the I-cache.
- d_req_read  in  1  D-cache line read request; level.
- d_req_write  in  1  D-cache line write (dirty flush) request; level.
- d_req_addr  in  32  D-cache request address; bits [4:0] ignored.
- d_write_data  in  256  line to write.
- d_done  out  1  one-cycle pulse: D-cache transaction complete.
- d_read_data  out  256  line returned to the D-cache (valid on a read).
- mem_req_read  out  1  memory read request; held until mem_done.
- mem_req_write  out  1  memory write request; held until mem_done.
- mem_addr  out  32  latched address, bits [4:0] forced to 0.
- mem_write_data  out  256  latched write line.
- mem_done  in  1  memory completion pulse.
- mem_read_data  in  256  memory read line, valid with mem_done.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Registered outputs. Reset value is 0 for every output and for the internal state.
- last_grant resets to D, so the I-cache wins the first round-robin tie.
- FSM states:
  - IDLE
  - BUSY_I
  - BUSY_D
  - RESP
- IDLE:
  - Samples requests at each edge.
  - With no request, the FSM stays in IDLE and mem_done is ignored.
  - With only one side requesting, that side is granted.
  - On a tie, D_PRIORITY=1 grants D; D_PRIORITY=0 grants the side opposite last_grant.
  - On grant, the FSM latches addr (with [4:0]=0), the op and write data, updates last_grant, and clears the counter.
  - The FSM then moves to BUSY_x, with mem_req_* high from the next cycle.
  - Request-to-mem_req latency is 1 cycle.
- D-cache op selection:
  - d_req_write=1 selects a write, even if d_req_read is also 1.
  - d_req_read alone selects a read.
- BUSY_x:
  - mem_req_read/mem_req_write stay constant; exactly one is high.
  - mem_addr and mem_write_data stay stable.
  - Requester inputs are ignored. Deasserting or changing the request mid-transaction does not cancel it; the transaction completes with the latched values.
- Normal completion:
  - mem_done sampled high in BUSY_x causes mem_req_* to drop at the same edge.
  - On a read, mem_read_data is captured into x_read_data.
  - The FSM moves to RESP, and x_done is high for exactly one cycle (the RESP cycle).
  - mem_done-to-x_done latency is 1 cycle.
  - On a write, d_read_data holds its previous value.
- Watchdog:
  - With TIMEOUT_CYCLES>0, the counter increments each BUSY cycle without mem_done.
  - When the counter reaches TIMEOUT_CYCLES: mem_req_* drop, x_read_data is set to 0, err_timeout sets, and the FSM enters RESP, pulsing x_done normally.
  - err_timeout stays set until rst.
  - mem_done and the timeout on the same edge count as normal completion.
- RESP:
  - Lasts one cycle, then the FSM returns to IDLE.
  - Requests are not arbitrated in RESP. This turnaround lets the requester drop its request after done without being re-served.
  - Minimum spacing between two mem_req assertions is 2 idle cycles.
- mem_done outside BUSY_x (a late or spurious pulse) is ignored, with no output change.
- rst mid-transaction:
  - The FSM goes to IDLE and all outputs clear at that edge. mem_req drops.
  - The pending transaction is abandoned, and a later mem_done is ignored.
- x_read_data holds its value between transactions. x_done never asserts for both sides in the same cycle.

Test Plan:
- I-only read, addr 0x0000_1234, mem_done 3 cycles after mem_req with data 0xA5..A5: mem_addr=0x0000_1220, mem_req_read high 3 cycles, i_done one pulse 1 cycle after mem_done, i_read_data=0xA5..A5, d_done stays 0.
- Simultaneous i_req_read and d_req_write (addr 0x8000_0040), D_PRIORITY=1: D granted first and mem_req_write high with d_write_data; after d_done and RESP, I granted; mem_req_read asserts 2 cycles after d_done.
- D_PRIORITY=0, both sides requesting continuously for 4 transactions: grant order I,D,I,D; no cycle has both mem_req_read and mem_req_write high.
- TIMEOUT_CYCLES=8, mem_done never asserted: mem_req drops after 8 busy cycles, i_done pulses with i_read_data=0, err_timeout=1 and stays 1 until rst.
- rst asserted 2 cycles into BUSY_D, then a stray mem_done 1 cycle after rst deasserts: all outputs 0, FSM idle, no d_done pulse.
- d_req_read and d_req_write both high: write is performed; requester drops d_req_read mid-BUSY: transaction still completes with one d_done.
